vector_line_sequencer: RTL

Frame-level controller for the Bresenham line engine in the vector display path. On each frame_start it walks a synchronous segment memory from address 0 and loads each entry's start and end coordinates. It fires one go per segment to the line engine and waits for that engine's done before fetching the next segment. It reports frame completion, the issued-line count and a watchdog timeout.

---
 rtl/vector_line_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vector_line_sequencer.sv
// Frame-level sequencer: walks the segment memory and feeds one line per entry to the line engine.
// Build option SEQ_SKIP_DEGENERATE_EN drops zero-length segments instead of issuing them.
module vector_line_sequencer #(
   parameter int BRES_WIDTH     = 9,
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  frame_start,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [4*BRES_WIDTH:0] mem_data,
   output logic                  line_go,
   output logic [BRES_WIDTH-1:0] stax,
   output logic [BRES_WIDTH-1:0] stay,
   output logic [BRES_WIDTH-1:0] endx,
   output logic [BRES_WIDTH-1:0] endy,
   input  logic                  line_busy,
   input  logic                  line_done,
   output logic                  busy,
   output logic                  frame_done,
   output logic [ADDR_WIDTH:0]   line_count,
   output logic                  timeout_err,
   output logic [2:0]            dbg_state_o
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_WIDTH:0]   CNT_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_LOAD      = 3'd2,
      S_ISSUE     = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_FINISH    = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  terr_q, terr_d;
   logic                  last_q, last_d;
   logic [BRES_WIDTH-1:0] stax_q, stax_d, stay_q, stay_d, endx_q, endx_d, endy_q, endy_d;
   logic [WD_W-1:0]       wdog_q, wdog_d;
   logic                  degenerate, at_end, wd_expired, abort;

`ifdef SEQ_SKIP_DEGENERATE_EN
   assign degenerate = (stax_q == endx_q) && (stay_q == endy_q);
`else
   assign degenerate = 1'b0;
`endif

   assign at_end     = last_q || (addr_q == ADDR_MAX);
   assign wd_expired = (wdog_q >= WD_LAST);
   assign abort      = rst || !enable;

   // Handshake: line_go is a one-cycle command; the engine accepts it only while line_busy is low.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      terr_d     = terr_q;
      last_d     = last_q;
      stax_d     = stax_q;
      stay_d     = stay_q;
      endx_d     = endx_q;
      endy_d     = endy_q;
      wdog_d     = wdog_q;
      line_go    = 1'b0;
      mem_rd     = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d = S_FETCH;
               addr_d  = '0;
               cnt_d   = '0;
               terr_d  = 1'b0;
            end
         end
         S_FETCH: begin
            mem_rd  = 1'b1;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            {last_d, stax_d, stay_d, endx_d, endy_d} = mem_data;
            wdog_d  = '0;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            wdog_d = wdog_q + WD_W'(1);
            if (degenerate) begin
               if (at_end) begin
                  state_d = S_FINISH;
               end else begin
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  state_d = S_FETCH;
               end
            end else if (!line_busy) begin
               line_go = 1'b1;
               state_d = S_WAIT_DONE;
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
            end else if (wd_expired) begin
               terr_d  = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_WAIT_DONE: begin
            wdog_d = wdog_q + WD_W'(1);
            if (line_done) begin
               if (at_end) begin
                  state_d = S_FINISH;
               end else begin
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  state_d = S_FETCH;
               end
            end else if (wd_expired) begin
               terr_d  = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Strobes are suppressed in the abort cycle so no command escapes a dying frame.
      if (abort) begin
         line_go    = 1'b0;
         mem_rd     = 1'b0;
         frame_done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
         last_q  <= 1'b0;
         stax_q  <= '0;
         stay_q  <= '0;
         endx_q  <= '0;
         endy_q  <= '0;
         wdog_q  <= '0;
      end else if (!enable) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         last_q  <= 1'b0;
         stax_q  <= '0;
         stay_q  <= '0;
         endx_q  <= '0;
         endy_q  <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
         last_q  <= last_d;
         stax_q  <= stax_d;
         stay_q  <= stay_d;
         endx_q  <= endx_d;
         endy_q  <= endy_d;
         wdog_q  <= wdog_d;
      end
   end

   assign mem_addr    = addr_q;
   assign stax        = stax_q;
   assign stay        = stay_q;
   assign endx        = endx_q;
   assign endy        = endy_q;
   assign busy        = (state_q != S_IDLE);
   assign line_count  = cnt_q;
   assign timeout_err = terr_q;
   assign dbg_state_o = state_q;

endmodule
